uart_rx_fifo: RTL and testbench

- Receive buffer directly downstream of the UART receiver.
- Accepts the receiver's AXI-Stream byte output into a first-word-fall-through FIFO and presents the bytes to the host on a second AXI-Stream interface.
- Turns the receiver's overrun_error and frame_error levels into sticky, host-clearable status and a saturating error counter.
- Drives an RTS-style flow-control output so the remote transmitter can be throttled before the buffer fills.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync_fifo.sv | 76 +++++++
 rtl/uart_rx_fifo.sv | 102 ++++++++++
 tb/tb_uart_rx_fifo.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer.
// Default widths, occupancy sizing and status bit positions.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Status vector bit positions
    localparam int OVR     = 0;
    localparam int FERR    = 1;
    localparam int NUM_ERR = 2;

    // Occupancy counter width: must hold 0..DEPTH inclusive
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Head entry is read combinationally from the registered read pointer.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0]      level,
    output logic [$clog2(DEPTH):0]      level_next,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = occ_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         count;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign level   = count;
    assign dout    = mem[rd_ptr];

    // Next occupancy; flush wins over any push or pop in the same cycle
    always_comb begin
        level_next = count;
        if (flush) begin
            level_next = '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10:   level_next = count + LW'(1);
                2'b01:   level_next = count - LW'(1);
                default: level_next = count;
            endcase
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= level_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Storage array is not reset; contents are meaningless after reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: FWFT FIFO, RTS
// flow control, sticky error status and frame-error counter.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   rx_overrun,
    input  logic                   rx_frame_err,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic                   flush,
    input  logic                   status_clear,
    output logic [$clog2(DEPTH):0] level,
    output logic                   rts_n,
    output logic                   overrun_sticky,
    output logic                   frame_err_sticky,
    output logic [CNT_WIDTH-1:0]   frame_err_cnt
);

    localparam int LW = occ_width(DEPTH);
    localparam logic [LW-1:0] AF = LW'(AF_LEVEL);

    logic [LW-1:0]      level_next;
    logic               full;
    logic               empty;
    logic [NUM_ERR-1:0] err_in;
    logic [NUM_ERR-1:0] err_q;
    logic [NUM_ERR-1:0] err_rise;
    logic [NUM_ERR-1:0] sticky;
    logic [CNT_WIDTH-1:0] cnt;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (s_axis_tvalid),
        .pop        (m_axis_tready),
        .flush      (flush),
        .din        (s_axis_tdata),
        .dout       (m_axis_tdata),
        .level      (level),
        .level_next (level_next),
        .full       (full),
        .empty      (empty)
    );

    assign s_axis_tready = ~full;
    assign m_axis_tvalid = ~empty;

    // RTS tracks next occupancy so it settles with the new level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rts_n <= 1'b0;
        else        rts_n <= (level_next >= AF);
    end

    assign err_in[OVR]  = rx_overrun;
    assign err_in[FERR] = rx_frame_err;
    assign err_rise     = err_in & ~err_q;

    // Delay error levels one cycle for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= err_in;
    end

    // Sticky bits: a same-cycle rising edge beats status_clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky & ~{NUM_ERR{status_clear}}) | err_rise;
        end
    end

    // Saturating frame-error counter; clear restarts at one on an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (status_clear) begin
            cnt <= err_rise[FERR] ? CNT_WIDTH'(1) : '0;
        end else if (err_rise[FERR] && (cnt != '1)) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign overrun_sticky   = sticky[OVR];
    assign frame_err_sticky = sticky[FERR];
    assign frame_err_cnt    = cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table-driven FIFO vectors
// plus hand-written sequences for flow control, status and reset.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       flush;
    logic       status_clear;
    logic [4:0] level;
    logic       rts_n;
    logic       overrun_sticky;
    logic       frame_err_sticky;
    logic [7:0] frame_err_cnt;

    int vecs = 0;
    int errs = 0;

    uart_rx_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .AF_LEVEL   (12),
        .CNT_WIDTH  (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .rx_overrun       (rx_overrun),
        .rx_frame_err     (rx_frame_err),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .flush            (flush),
        .status_clear     (status_clear),
        .level            (level),
        .rts_n            (rts_n),
        .overrun_sticky   (overrun_sticky),
        .frame_err_sticky (frame_err_sticky),
        .frame_err_cnt    (frame_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic [4:0] lvl;
        logic       tv;
        logic [7:0] td;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_b;

        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        rx_overrun    = 1'b0;
        rx_frame_err  = 1'b0;
        m_axis_tready = 1'b0;
        flush         = 1'b0;
        status_clear  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_level", 32'(level), 0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_tready", 32'(s_axis_tready), 1);
        chk("rst_rts", 32'(rts_n), 0);
        chk("rst_cnt", 32'(frame_err_cnt), 0);

        // {s_valid, s_data, m_ready, level, tvalid, tdata} after edge
        tbl[0] = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b1, 8'h11};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 5'd2, 1'b1, 8'h11};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 5'd3, 1'b1, 8'h11};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'h22};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h33};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};
        tbl[6] = '{1'b1, 8'h44, 1'b1, 5'd1, 1'b1, 8'h44};
        tbl[7] = '{1'b1, 8'h55, 1'b1, 5'd1, 1'b1, 8'h55};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};

        for (int i = 0; i < 9; i++) begin
            s_axis_tvalid = tbl[i].sv;
            s_axis_tdata  = tbl[i].sd;
            m_axis_tready = tbl[i].mr;
            tick();
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_tvalid", i), 32'(m_axis_tvalid),
                32'(tbl[i].tv));
            if (tbl[i].tv)
                chk($sformatf("tbl%0d_tdata", i), 32'(m_axis_tdata),
                    32'(tbl[i].td));
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;

        // Fill to full, watch RTS threshold
        for (int k = 1; k <= 16; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 8'(8'hA0 + k - 1);
            tick();
            chk($sformatf("fill%0d_level", k), 32'(level), 32'(k));
            chk($sformatf("fill%0d_rts", k), 32'(rts_n), 32'(k >= 12));
        end
        chk("full_tready", 32'(s_axis_tready), 0);
        s_axis_tdata = 8'hFF;
        tick();
        chk("full_no_push", 32'(level), 16);
        chk("full_head", 32'(m_axis_tdata), 32'h A0);
        s_axis_tdata  = 8'hEE;
        m_axis_tready = 1'b1;
        tick();
        chk("full_pop_level", 32'(level), 15);
        chk("full_pop_tready", 32'(s_axis_tready), 1);
        m_axis_tready = 1'b0;
        tick();
        chk("wrap_push_level", 32'(level), 16);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_b = (k < 15) ? 8'(8'hA1 + k) : 8'hEE;
            chk($sformatf("drain%0d", k), 32'(m_axis_tdata), 32'(exp_b));
            tick();
        end
        chk("drain_level", 32'(level), 0);
        chk("drain_rts", 32'(rts_n), 0);
        m_axis_tready = 1'b0;

        // Simultaneous push/pop at level 5
        for (int k = 0; k < 5; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 8'(8'h30 + k);
            q.push_back(s_axis_tdata);
            tick();
        end
        m_axis_tready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("pp%0d_data", k), 32'(m_axis_tdata), 32'(q[0]));
            s_axis_tdata = 8'(8'h40 + k);
            tick();
            void'(q.pop_front());
            q.push_back(8'(8'h40 + k));
            chk($sformatf("pp%0d_level", k), 32'(level), 5);
        end
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("pp_tail%0d", k), 32'(m_axis_tdata), 32'(q[0]));
            void'(q.pop_front());
            tick();
        end
        chk("pp_empty", 32'(m_axis_tvalid), 0);
        m_axis_tready = 1'b0;

        // Frame-error edges and saturation
        for (int k = 0; k < 2; k++) begin
            rx_frame_err = 1'b1;
            tick();
            rx_frame_err = 1'b0;
            tick();
        end
        rx_frame_err = 1'b1;
        repeat (300) tick();
        chk("ferr_cnt3", 32'(frame_err_cnt), 3);
        chk("ferr_sticky", 32'(frame_err_sticky), 1);
        for (int k = 0; k < 260; k++) begin
            rx_frame_err = 1'b0;
            tick();
            rx_frame_err = 1'b1;
            tick();
        end
        chk("ferr_sat", 32'(frame_err_cnt), 32'hFF);
        rx_frame_err = 1'b0;
        tick();
        status_clear = 1'b1;
        tick();
        chk("clr_cnt", 32'(frame_err_cnt), 0);
        chk("clr_sticky", 32'(frame_err_sticky), 0);
        rx_frame_err = 1'b1;
        tick();
        chk("clr_edge_cnt", 32'(frame_err_cnt), 1);
        chk("clr_edge_sticky", 32'(frame_err_sticky), 1);
        rx_frame_err = 1'b0;
        status_clear = 1'b0;
        tick();

        // Overrun edge vs clear
        rx_overrun   = 1'b1;
        status_clear = 1'b1;
        tick();
        chk("ovr_edge_wins", 32'(overrun_sticky), 1);
        tick();
        chk("ovr_clear", 32'(overrun_sticky), 0);
        status_clear = 1'b0;
        tick();
        chk("ovr_held_no_reset", 32'(overrun_sticky), 0);
        rx_overrun = 1'b0;
        tick();

        // Mid-burst asynchronous reset
        rx_overrun = 1'b1;
        for (int k = 0; k < 7; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 8'(8'h60 + k);
            tick();
        end
        chk("burst_level", 32'(level), 7);
        chk("burst_ovr", 32'(overrun_sticky), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 0);
        chk("arst_tvalid", 32'(m_axis_tvalid), 0);
        chk("arst_rts", 32'(rts_n), 0);
        chk("arst_ovr", 32'(overrun_sticky), 0);
        chk("arst_ferr", 32'(frame_err_sticky), 0);
        s_axis_tvalid = 1'b0;
        rx_overrun    = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Flush together with a push
        rx_overrun    = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h71;
        tick();
        s_axis_tdata = 8'h72;
        tick();
        chk("pre_flush_level", 32'(level), 2);
        flush        = 1'b1;
        s_axis_tdata = 8'h73;
        tick();
        chk("flush_level", 32'(level), 0);
        chk("flush_tvalid", 32'(m_axis_tvalid), 0);
        chk("flush_keeps_ovr", 32'(overrun_sticky), 1);
        flush        = 1'b0;
        s_axis_tdata = 8'h74;
        tick();
        s_axis_tvalid = 1'b0;
        chk("post_flush_level", 32'(level), 1);
        chk("post_flush_data", 32'(m_axis_tdata), 32'h74);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
